// File: rtl/tx_report_pkg.sv
// Shared types and constants for the UART report scheduler: FSM states,
// grant identifiers, frame geometry and default header bytes.
package tx_report_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT,
        ACK
    } state_t;

    typedef enum logic {
        GNT_MATCH,
        GNT_PROG
    } grant_t;

    localparam int unsigned PROG_FRAME_LEN  = 6;
    localparam int unsigned MAX_FRAME_BYTES = 18;
    localparam int unsigned FRAME_W         = MAX_FRAME_BYTES * 8;
    localparam int unsigned CNT_W           = 5;

    localparam logic [7:0] DEF_HDR_MATCH = 8'hA5;
    localparam logic [7:0] DEF_HDR_PROG  = 8'h5A;

    // Saturate a requested password length to the frame's payload capacity.
    function automatic logic [CNT_W-1:0] clamp_len(input logic [4:0] len,
                                                   input int unsigned max_len);
        if (32'(len) > max_len) begin
            return CNT_W'(max_len);
        end
        return len;
    endfunction

endpackage

// File: rtl/tx_frame_buffer.sv
// Frame holding register: parallel load of a whole report frame, then
// byte-wise shift-out from the top with a count of bytes still to go.
module tx_frame_buffer
    import tx_report_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               shift,
    input  logic [FRAME_W-1:0] frame,
    input  logic [CNT_W-1:0]   length,
    output logic [7:0]         top_byte,
    output logic               empty
);

    logic [FRAME_W-1:0] data_q;
    logic [CNT_W-1:0]   count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            count_q <= '0;
        end else if (load) begin
            data_q  <= frame;
            count_q <= length;
        end else if (shift && (count_q != '0)) begin
            data_q  <= {data_q[FRAME_W-9:0], 8'h00};
            count_q <= count_q - CNT_W'(1);
        end
    end

    always_comb begin
        top_byte = data_q[FRAME_W-1 -: 8];
        empty    = (count_q == '0);
    end

endmodule

// File: rtl/tx_report_scheduler.sv
// Round-robin sharing of the UART byte transmitter between the match and
// progress reporters; frames each report and paces it through tx_start/tx_done.
module tx_report_scheduler
    import tx_report_pkg::*;
#(
    parameter int unsigned MAX_PWD_BYTES = 16,
    parameter logic [7:0]  HDR_MATCH     = DEF_HDR_MATCH,
    parameter logic [7:0]  HDR_PROG      = DEF_HDR_PROG
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         match_req,
    input  logic [4:0]   match_len,
    input  logic [127:0] match_data,
    output logic         match_ack,
    input  logic         prog_req,
    input  logic [3:0]   prog_strlen,
    input  logic [31:0]  prog_count,
    output logic         prog_ack,
    output logic [7:0]   tx_byte,
    output logic         tx_start,
    input  logic         tx_done,
    output logic         busy
);

    state_t state;
    state_t next_state;
    grant_t last_grant;
    grant_t grant_sel;

    logic               req_any;
    logic [CNT_W-1:0]   match_len_c;
    logic [FRAME_W-1:0] frame_sel;
    logic [CNT_W-1:0]   len_sel;

    logic       buf_load;
    logic       buf_shift;
    logic       buf_empty;
    logic [7:0] buf_top;

    logic       tx_start_d;
    logic [7:0] tx_byte_d;
    logic       match_ack_d;
    logic       prog_ack_d;
    logic       busy_d;

    // Arbiter: a tie goes to whichever source was not served last.
    always_comb begin
        req_any   = match_req | prog_req;
        grant_sel = GNT_MATCH;
        if (match_req && prog_req) begin
            grant_sel = (last_grant == GNT_PROG) ? GNT_MATCH : GNT_PROG;
        end else if (prog_req) begin
            grant_sel = GNT_PROG;
        end
    end

    always_comb begin
        match_len_c = clamp_len(match_len, MAX_PWD_BYTES);
        if (grant_sel == GNT_MATCH) begin
            frame_sel = {HDR_MATCH, 3'b000, match_len_c, match_data};
            len_sel   = match_len_c + CNT_W'(2);
        end else begin
            frame_sel = {HDR_PROG, 4'h0, prog_strlen, prog_count, {(FRAME_W-48){1'b0}}};
            len_sel   = CNT_W'(PROG_FRAME_LEN);
        end
    end

    tx_frame_buffer u_frame_buffer (
        .clk      (clk),
        .rst      (rst),
        .load     (buf_load),
        .shift    (buf_shift),
        .frame    (frame_sel),
        .length   (len_sel),
        .top_byte (buf_top),
        .empty    (buf_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: if (req_any) next_state = SEND;
            SEND: next_state = WAIT;
            WAIT: if (tx_done) next_state = buf_empty ? ACK : SEND;
            ACK:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs are computed one cycle ahead and registered. The buffer is
    // shifted during SEND rather than on tx_done, so in WAIT its top byte is
    // already the next one to send and the counter holds bytes not yet started.
    always_comb begin
        buf_load    = (state == IDLE) && req_any;
        buf_shift   = (state == SEND);
        tx_start_d  = (next_state == SEND);
        busy_d      = (next_state != IDLE);
        match_ack_d = (state == WAIT) && (next_state == ACK) && (last_grant == GNT_MATCH);
        prog_ack_d  = (state == WAIT) && (next_state == ACK) && (last_grant == GNT_PROG);
        tx_byte_d   = tx_byte;
        if (buf_load) begin
            tx_byte_d = frame_sel[FRAME_W-1 -: 8];
        end else if ((state == WAIT) && (next_state == SEND)) begin
            tx_byte_d = buf_top;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_start   <= 1'b0;
            tx_byte    <= '0;
            match_ack  <= 1'b0;
            prog_ack   <= 1'b0;
            busy       <= 1'b0;
            last_grant <= GNT_PROG;
        end else begin
            tx_start  <= tx_start_d;
            tx_byte   <= tx_byte_d;
            match_ack <= match_ack_d;
            prog_ack  <= prog_ack_d;
            busy      <= busy_d;
            if (buf_load) begin
                last_grant <= grant_sel;
            end
        end
    end

endmodule

// File: tb/tb_tx_report_scheduler.sv
// Scoreboard bench for tx_report_scheduler: expected frame bytes are queued
// when a request is raised and checked as the scheduler emits tx_start.
module tb_tx_report_scheduler;

    logic         clk;
    logic         rst;
    logic         match_req;
    logic [4:0]   match_len;
    logic [127:0] match_data;
    logic         match_ack;
    logic         prog_req;
    logic [3:0]   prog_strlen;
    logic [31:0]  prog_count;
    logic         prog_ack;
    logic [7:0]   tx_byte;
    logic         tx_start;
    logic         tx_done;
    logic         busy;

    int tests  = 0;
    int failed = 0;
    logic [7:0] exp_q[$];

    tx_report_scheduler #(
        .MAX_PWD_BYTES (16),
        .HDR_MATCH     (8'hA5),
        .HDR_PROG      (8'h5A)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .match_req   (match_req),
        .match_len   (match_len),
        .match_data  (match_data),
        .match_ack   (match_ack),
        .prog_req    (prog_req),
        .prog_strlen (prog_strlen),
        .prog_count  (prog_count),
        .prog_ack    (prog_ack),
        .tx_byte     (tx_byte),
        .tx_start    (tx_start),
        .tx_done     (tx_done),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_prog(input logic [3:0] strlen, input logic [31:0] count);
        exp_q.push_back(8'h5A);
        exp_q.push_back({4'h0, strlen});
        exp_q.push_back(count[31:24]);
        exp_q.push_back(count[23:16]);
        exp_q.push_back(count[15:8]);
        exp_q.push_back(count[7:0]);
    endtask

    task automatic push_match(input int len, input logic [127:0] data);
        int l;
        l = (len > 16) ? 16 : len;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'(l));
        for (int i = 0; i < l; i++) begin
            exp_q.push_back(data[127 - 8*i -: 8]);
        end
    endtask

    // Wait for one tx_start, score its byte, then answer with tx_done after
    // delay cycles. Returns in the cycle after the tx_done pulse.
    task automatic serve_byte(input string tag, input int delay, output bit ok);
        int cyc;
        logic [7:0] got;
        logic [7:0] exp_b;
        cyc = 0;
        ok = 1'b0;
        while (tx_start !== 1'b1 && cyc < 40) begin
            step();
            cyc++;
        end
        tests++;
        if (tx_start !== 1'b1) begin
            failed++;
            $display("FAIL %s start_timeout: tx_start=%b required=1", tag, tx_start);
            return;
        end
        got = tx_byte;
        tests++;
        if (exp_q.size() == 0) begin
            failed++;
            $display("FAIL %s unexpected_byte: tx_byte=%h required=none", tag, got);
        end else begin
            exp_b = exp_q.pop_front();
            if (got !== exp_b) begin
                failed++;
                $display("FAIL %s byte: tx_byte=%h required=%h", tag, got, exp_b);
            end
        end
        step();
        tests++;
        if (tx_start !== 1'b0) begin
            failed++;
            $display("FAIL %s start_pulse: tx_start=%b required=0", tag, tx_start);
        end
        repeat (delay - 1) step();
        tests++;
        if (tx_byte !== got) begin
            failed++;
            $display("FAIL %s byte_hold: tx_byte=%h required=%h", tag, tx_byte, got);
        end
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        ok = 1'b1;
    endtask

    // Serve a whole frame, check the ack cycle, drop requests, check idle.
    task automatic serve_frame(input string tag, input int nbytes, input bit is_match,
                               input bit drop_m, input bit drop_p);
        bit ok;
        for (int i = 0; i < nbytes; i++) begin
            serve_byte(tag, int'($urandom_range(3, 1)), ok);
            if (!ok) begin
                match_req = 1'b0;
                prog_req  = 1'b0;
                return;
            end
            if (i < nbytes - 1) begin
                tests++;
                if (tx_start !== 1'b1) begin
                    failed++;
                    $display("FAIL %s next_start: tx_start=%b required=1 (byte %0d)", tag, tx_start, i + 1);
                end
            end
        end
        tests++;
        if (match_ack !== is_match || prog_ack !== !is_match) begin
            failed++;
            $display("FAIL %s ack: match_ack=%b prog_ack=%b required=%b/%b",
                     tag, match_ack, prog_ack, is_match, !is_match);
        end
        tests++;
        if (busy !== 1'b1 || tx_start !== 1'b0) begin
            failed++;
            $display("FAIL %s ack_cycle: busy=%b tx_start=%b required=1/0", tag, busy, tx_start);
        end
        if (drop_m) match_req = 1'b0;
        if (drop_p) prog_req = 1'b0;
        step();
        tests++;
        if ({match_ack, prog_ack, busy, tx_start} !== 4'b0000) begin
            failed++;
            $display("FAIL %s post_ack: ack=%b%b busy=%b tx_start=%b required=0000",
                     tag, match_ack, prog_ack, busy, tx_start);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        tests++;
        if ({tx_byte, tx_start, match_ack, prog_ack, busy} !== 12'h000) begin
            failed++;
            $display("FAIL reset_outputs: tx_byte=%h start=%b acks=%b%b busy=%b required=all zero",
                     tx_byte, tx_start, match_ack, prog_ack, busy);
        end
        rst = 1'b0;
        step();
        tests++;
        if (busy !== 1'b0 || tx_start !== 1'b0) begin
            failed++;
            $display("FAIL reset_idle: busy=%b tx_start=%b required=0/0", busy, tx_start);
        end
    endtask

    task automatic test_prog_only();
        prog_strlen = 4'd3;
        prog_count  = 32'h0001_2345;
        push_prog(prog_strlen, prog_count);
        prog_req = 1'b1;
        step();
        tests++;
        if (tx_start !== 1'b1 || busy !== 1'b1) begin
            failed++;
            $display("FAIL prog_latency: tx_start=%b busy=%b required=1/1", tx_start, busy);
        end
        serve_frame("prog_only", 6, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_match_only();
        match_len  = 5'd2;
        match_data = {8'h61, 8'h62, 112'h0};
        push_match(2, match_data);
        match_req = 1'b1;
        serve_frame("match_only", 4, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [127:0] d2;
        // Fresh reset so the first tie is arbitrated from last_grant=PROG.
        rst = 1'b1;
        step();
        rst = 1'b0;
        match_len   = 5'd3;
        match_data  = {8'h6E, 8'h74, 8'h6C, 104'h0};
        prog_strlen = 4'd5;
        prog_count  = 32'hCAFE_0042;
        push_match(3, match_data);
        match_req = 1'b1;
        prog_req  = 1'b1;
        serve_frame("rr_match_first", 5, 1'b1, 1'b1, 1'b0);
        d2 = {8'h7A, 120'h0};
        match_len  = 5'd1;
        match_data = d2;
        push_prog(prog_strlen, prog_count);
        push_match(1, d2);
        match_req = 1'b1;
        step();
        tests++;
        if (tx_start !== 1'b1 || tx_byte !== 8'h5A) begin
            failed++;
            $display("FAIL rr_prog_next: tx_start=%b tx_byte=%h required=1/5a", tx_start, tx_byte);
        end
        serve_frame("rr_prog", 6, 1'b0, 1'b0, 1'b1);
        serve_frame("rr_match_last", 3, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_len_bounds();
        logic [127:0] d;
        d = {$urandom, $urandom, $urandom, $urandom};
        match_len  = 5'd0;
        match_data = d;
        push_match(0, d);
        match_req = 1'b1;
        serve_frame("len_zero", 2, 1'b1, 1'b1, 1'b0);
        d = {$urandom, $urandom, $urandom, $urandom};
        match_len  = 5'd20;
        match_data = d;
        push_match(20, d);
        match_req = 1'b1;
        serve_frame("len_clamp", 18, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        prog_strlen = 4'd9;
        prog_count  = 32'h0BAD_F00D;
        push_prog(prog_strlen, prog_count);
        prog_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            serve_byte("rst_mid", 2, ok);
        end
        rst      = 1'b1;
        prog_req = 1'b0;
        step();
        tests++;
        if ({tx_byte, tx_start, match_ack, prog_ack, busy} !== 12'h000) begin
            failed++;
            $display("FAIL rst_mid_outputs: tx_byte=%h start=%b acks=%b%b busy=%b required=all zero",
                     tx_byte, tx_start, match_ack, prog_ack, busy);
        end
        rst = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 5; i++) begin
            step();
            tests++;
            if (prog_ack !== 1'b0 || tx_start !== 1'b0) begin
                failed++;
                $display("FAIL rst_mid_quiet: prog_ack=%b tx_start=%b required=0/0", prog_ack, tx_start);
            end
        end
        prog_count = 32'h0000_0007;
        push_prog(prog_strlen, prog_count);
        prog_req = 1'b1;
        serve_frame("rst_restart", 6, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_snapshot();
        prog_strlen = 4'd7;
        prog_count  = 32'hDEAD_BEEF;
        push_prog(prog_strlen, prog_count);
        prog_req = 1'b1;
        step();
        prog_strlen = 4'd2;
        prog_count  = 32'h1111_1111;
        serve_frame("snapshot", 6, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_idle_done();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (tx_start !== 1'b0 || busy !== 1'b0) begin
                failed++;
                $display("FAIL idle_done: tx_start=%b busy=%b required=0/0", tx_start, busy);
            end
            step();
        end
        prog_strlen = 4'd1;
        prog_count  = 32'h8000_0001;
        push_prog(prog_strlen, prog_count);
        prog_req = 1'b1;
        serve_frame("idle_done_after", 6, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        rst         = 1'b1;
        match_req   = 1'b0;
        match_len   = '0;
        match_data  = '0;
        prog_req    = 1'b0;
        prog_strlen = '0;
        prog_count  = '0;
        tx_done     = 1'b0;
        step();
        test_reset();
        test_prog_only();
        test_match_only();
        test_back_to_back();
        test_len_bounds();
        test_reset_mid_frame();
        test_snapshot();
        test_idle_done();
        tests++;
        if (exp_q.size() != 0) begin
            failed++;
            $display("FAIL scoreboard_drain: %0d bytes left required=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
